// File: rtl/rpc2_ctrl_mem_reset_gen.sv
// Drives the memory RESET# pin: timed low pulse, recovery wait, then ready.
// Optional power-up hold on the first pulse: define RPC2_CTRL_MEM_POWERUP_WAIT_EN.
module rpc2_ctrl_mem_reset_gen #(
  parameter int PULSE_CYCLES    = 16,
  parameter int RECOVERY_CYCLES = 64,
  parameter int POWERUP_CYCLES  = 1024,
  parameter int CNT_W           = 12
) (
  input  logic clk,
  input  logic areset_n,
  input  logic rst_req,
  output logic mem_reset_n,
  output logic mem_ready,
  output logic rst_done,
  output logic busy
);

`ifdef RPC2_CTRL_MEM_POWERUP_WAIT_EN
  // One extra bit so the counter can hold POWERUP_CYCLES + PULSE_CYCLES - 1.
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  localparam logic [CW-1:0] LOAD_PULSE   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_RECOVER = CW'(RECOVERY_CYCLES - 1);

  // Elaboration-time guard against counter loads that would not fit.
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > (1 << CNT_W) ||
      RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > (1 << CNT_W) ||
      POWERUP_CYCLES < 1 || POWERUP_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("rpc2_ctrl_mem_reset_gen: cycle parameter out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RECOVER = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pending_reg, pending_next;
  logic          mem_reset_n_reg, mem_reset_n_next;
  logic          mem_ready_reg, mem_ready_next;
  logic          rst_done_reg, rst_done_next;
  logic          busy_reg, busy_next;
  logic [CW-1:0] load_assert;
  logic [CW-1:0] load_reset;
  logic          cnt_zero;

`ifdef RPC2_CTRL_MEM_POWERUP_WAIT_EN
  localparam logic [CW-1:0] LOAD_FIRST = CW'(POWERUP_CYCLES + PULSE_CYCLES - 1);

  logic first_pulse_reg, first_pulse_next;

  // Only the pulse that follows areset_n carries the power-up hold.
  assign load_assert = first_pulse_reg ? LOAD_FIRST : LOAD_PULSE;
  assign load_reset  = LOAD_FIRST;

  always_comb begin
    first_pulse_next = first_pulse_reg;
    if (state_reg == ST_ASSERT && cnt_zero) begin
      first_pulse_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      first_pulse_reg <= 1'b1;
    end else begin
      first_pulse_reg <= first_pulse_next;
    end
  end
`else
  assign load_assert = LOAD_PULSE;
  assign load_reset  = LOAD_PULSE;
`endif

  assign cnt_zero = (cnt_reg == '0);

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    // Saturating decrement: the counter parks at zero.
    cnt_next     = cnt_zero ? cnt_reg : cnt_reg - CW'(1);

    unique case (state_reg)
      ST_ASSERT: begin
        if (cnt_zero) begin
          state_next = ST_RECOVER;
          cnt_next   = LOAD_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          // A request landing on the final cycle is treated as pending.
          if (pending_reg || rst_req) begin
            state_next   = ST_ASSERT;
            cnt_next     = load_assert;
            pending_next = 1'b0;
          end else begin
            state_next = ST_READY;
          end
        end else if (rst_req) begin
          pending_next = 1'b1;
        end
      end
      ST_READY: begin
        if (rst_req) begin
          state_next = ST_ASSERT;
          cnt_next   = load_assert;
        end
      end
      default: begin
        state_next   = ST_ASSERT;
        cnt_next     = load_assert;
        pending_next = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pin never glitches.
  always_comb begin
    mem_reset_n_next = (state_next != ST_ASSERT);
    mem_ready_next   = (state_next == ST_READY);
    rst_done_next    = (state_reg == ST_RECOVER) && (state_next == ST_READY);
    busy_next        = (state_next != ST_READY);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg       <= ST_ASSERT;
      cnt_reg         <= load_reset;
      pending_reg     <= 1'b0;
      mem_reset_n_reg <= 1'b0;
      mem_ready_reg   <= 1'b0;
      rst_done_reg    <= 1'b0;
      busy_reg        <= 1'b1;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pending_reg     <= pending_next;
      mem_reset_n_reg <= mem_reset_n_next;
      mem_ready_reg   <= mem_ready_next;
      rst_done_reg    <= rst_done_next;
      busy_reg        <= busy_next;
    end
  end

  assign mem_reset_n = mem_reset_n_reg;
  assign mem_ready   = mem_ready_reg;
  assign rst_done    = rst_done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_rpc2_ctrl_mem_reset_gen.sv
// Directed bench for rpc2_ctrl_mem_reset_gen; observes {mem_reset_n, mem_ready, rst_done, busy}.
// Honors RPC2_CTRL_MEM_POWERUP_WAIT_EN for the first pulse length.
module tb_rpc2_ctrl_mem_reset_gen;

  localparam int PULSE    = 4;
  localparam int RECOVERY = 6;
  localparam int POWERUP  = 10;
`ifdef RPC2_CTRL_MEM_POWERUP_WAIT_EN
  localparam int FIRST_LOW = POWERUP + PULSE;
`else
  localparam int FIRST_LOW = PULSE;
`endif

  // {mem_reset_n, mem_ready, rst_done, busy}
  localparam logic [3:0] V_ASSERT  = 4'b0001;
  localparam logic [3:0] V_RECOVER = 4'b1001;
  localparam logic [3:0] V_DONE    = 4'b1110;
  localparam logic [3:0] V_READY   = 4'b1100;

  logic clk = 1'b0;
  logic areset_n;
  logic rst_req;
  logic mem_reset_n, mem_ready, rst_done, busy;
  logic [3:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  rpc2_ctrl_mem_reset_gen #(
    .PULSE_CYCLES   (PULSE),
    .RECOVERY_CYCLES(RECOVERY),
    .POWERUP_CYCLES (POWERUP),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .rst_req    (rst_req),
    .mem_reset_n(mem_reset_n),
    .mem_ready  (mem_ready),
    .rst_done   (rst_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign obs = {mem_reset_n, mem_ready, rst_done, busy};

  task automatic check(input string tag, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Hold rst_req across one rising edge, then check outputs on the falling edge.
  task automatic cyc(input string tag, input logic [3:0] exp, input logic req);
    rst_req = req;
    @(posedge clk);
    @(negedge clk);
    rst_req = 1'b0;
    check(tag, exp);
  endtask

  task automatic run_seq(input string tag, input int n_low);
    repeat (n_low) cyc({tag, "_low"}, V_ASSERT, 1'b0);
    repeat (RECOVERY) cyc({tag, "_rec"}, V_RECOVER, 1'b0);
    cyc({tag, "_done"}, V_DONE, 1'b0);
    cyc({tag, "_ready"}, V_READY, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 1'b0;
    rst_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_values", V_ASSERT);

    // Power-on sequence: pin rises on the FIRST_LOW-th edge after release.
    areset_n = 1'b1;
    run_seq("por", FIRST_LOW - 1);
    cyc("por_idle", V_READY, 1'b0);

    // Request in READY: normal 4-cycle pulse regardless of power-up option.
    cyc("req_ready_fall", V_ASSERT, 1'b1);
    run_seq("req_ready", PULSE - 1);

    // Request during ASSERT is ignored: no lengthening, no second pulse.
    cyc("req_assert_c1", V_ASSERT, 1'b1);
    cyc("req_assert_c2", V_ASSERT, 1'b0);
    cyc("req_assert_c3", V_ASSERT, 1'b1);
    cyc("req_assert_c4", V_ASSERT, 1'b0);
    repeat (RECOVERY) cyc("req_assert_rec", V_RECOVER, 1'b0);
    cyc("req_assert_done", V_DONE, 1'b0);
    repeat (3) cyc("req_assert_idle", V_READY, 1'b0);

    // Request in RECOVER cycle 3: pending pulse after exactly RECOVERY high cycles.
    cyc("req_rec3_fall", V_ASSERT, 1'b1);
    repeat (PULSE - 1) cyc("req_rec3_low1", V_ASSERT, 1'b0);
    cyc("req_rec3_rec1", V_RECOVER, 1'b0);
    cyc("req_rec3_rec2", V_RECOVER, 1'b0);
    cyc("req_rec3_rec3", V_RECOVER, 1'b1);
    repeat (RECOVERY - 3) cyc("req_rec3_rec", V_RECOVER, 1'b0);
    run_seq("req_rec3_second", PULSE);

    // Request on RECOVER's final cycle: also goes straight back to ASSERT.
    cyc("req_recN_fall", V_ASSERT, 1'b1);
    repeat (PULSE - 1) cyc("req_recN_low1", V_ASSERT, 1'b0);
    repeat (RECOVERY) cyc("req_recN_rec1", V_RECOVER, 1'b0);
    cyc("req_recN_again", V_ASSERT, 1'b1);
    run_seq("req_recN_second", PULSE - 1);

    // areset_n mid-RECOVER with pending set: immediate reset, pending discarded.
    cyc("areset_fall", V_ASSERT, 1'b1);
    repeat (PULSE - 1) cyc("areset_low", V_ASSERT, 1'b0);
    cyc("areset_rec1", V_RECOVER, 1'b0);
    cyc("areset_rec2", V_RECOVER, 1'b1);
    #2;
    areset_n = 1'b0;
    #1;
    check("areset_async", V_ASSERT);
    @(negedge clk);
    check("areset_held", V_ASSERT);
    areset_n = 1'b1;
    run_seq("areset_after", FIRST_LOW - 1);
    repeat (3) cyc("areset_no_extra", V_READY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rpc2_ctrl_mem_reset_gen.md
# rpc2_ctrl_mem_reset_gen

Drives the hardware reset pin (RESET#) of the attached HyperBus/Xccela memory device from the controller clock domain. After controller reset and on software request, it generates a clean, registered, minimum-width reset pulse and then enforces the post-reset recovery time. Only after both have elapsed does it declare the device ready. It is the pin-driving counterpart of the controller's reset/RSTO# synchronizer and sits between the register block (request) and the pad ring (pin).

## Interface
Parameters:
- PULSE_CYCLES, 16: clk cycles RESET# is held low per pulse (tRP); legal range 1..2^CNT_W.
- RECOVERY_CYCLES, 64: clk cycles from RESET# release to ready (tRH); legal range 1..2^CNT_W.
- POWERUP_CYCLES, 1024: extra low-hold on the first pulse after areset_n (tVCS); legal range 1..2^CNT_W.
- CNT_W, 12: width of the shared down-counter.

Ports:
- clk  input  1  controller clock.
- areset_n  input  1  asynchronous, active-low reset.
- rst_req  input  1  single-cycle request for a device reset; synchronous to clk.
- mem_reset_n  output  1  to RESET# pad; registered, glitch-free; 0 = device in reset.
- mem_ready  output  1  registered; 1 = device out of reset and recovery complete.
- rst_done  output  1  one-cycle pulse on the cycle mem_ready rises.
- busy  output  1  registered; 1 in ASSERT or RECOVER.

## Operation
- States: ASSERT, RECOVER, READY. Reset state is ASSERT.
- Reset values: mem_reset_n=0, mem_ready=0, rst_done=0, busy=1, pending=0.
- Counter: a single down-counter, CNT_W bits. It is loaded with N-1 on state entry and leaves the state on the cycle after it reads 0. No wrap: it never decrements below 0.
- ASSERT: mem_reset_n=0, busy=1. Runs PULSE_CYCLES cycles, then goes to RECOVER.
- RECOVER: mem_reset_n=1, busy=1. Runs RECOVERY_CYCLES cycles. At the end:
  - pending=1: go to ASSERT, clear pending, no rst_done.
  - pending=0: go to READY, mem_ready=1, rst_done=1 for one cycle.
- READY: mem_reset_n=1, mem_ready=1, busy=0. rst_req=1 goes to ASSERT on the next edge; mem_ready falls on that same edge.
- rst_req handling by state:
  - In ASSERT: ignored, because a pulse is already in progress. The pulse is not lengthened.
  - In RECOVER: sets pending. Multiple requests collapse into one pending pulse.
  - Same cycle the RECOVER counter expires: counts as pending, so the block goes straight to ASSERT.
- areset_n assertion at any time, including mid-pulse or mid-recovery: all outputs return to reset values immediately (asynchronous) and pending clears.

## Timing
- All outputs come straight from flops; there is no combinational path from rst_req to any output.
- After areset_n release, the first pulse's low time is PULSE_CYCLES clk cycles, plus POWERUP_CYCLES when the macro is enabled. This is counted from the first rising clk edge after release.
- Request latency: rst_req sampled high in READY at edge k gives mem_reset_n=0 and mem_ready=0 after edge k. mem_reset_n is low for exactly PULSE_CYCLES cycles.
- Release-to-ready: mem_reset_n rises at edge j. mem_ready and rst_done rise at edge j+RECOVERY_CYCLES.
- Pending back-to-back case: mem_reset_n is high for exactly RECOVERY_CYCLES cycles between the two pulses. mem_ready stays 0 throughout.

## Configuration
- RPC2_CTRL_MEM_POWERUP_WAIT_EN defined: the first ASSERT after areset_n uses a low time of POWERUP_CYCLES+PULSE_CYCLES. This uses a one-bit first_pulse flag (reset value 1), cleared on leaving that first ASSERT. The counter must hold POWERUP_CYCLES+PULSE_CYCLES-1; the implementation widens it internally by 1 bit.
- Undefined: every pulse, including the first, is PULSE_CYCLES. POWERUP_CYCLES is unused and first_pulse logic is absent.

## Test plan
Parameters for all tests: PULSE=4, RECOVERY=6, POWERUP=10, CNT_W=8.
- areset_n release, macro off: mem_reset_n low 4 cycles, then high; mem_ready and rst_done rise 6 cycles later; rst_done is high exactly 1 cycle.
- areset_n release, macro on: first low time 14 cycles. A later rst_req in READY gives a 4-cycle low time.
- rst_req pulse in READY: mem_ready falls next edge; 4 low, 6 recovery; rst_done pulses once.
- rst_req during ASSERT cycle 2: pulse still 4 cycles; no second pulse; a single rst_done.
- rst_req during RECOVER cycle 3, and separately on RECOVER's final cycle: second 4-cycle pulse follows exactly 6 high cycles; mem_ready stays 0 until the second recovery ends; one rst_done total.
- areset_n asserted mid-RECOVER with pending set: mem_reset_n=0, mem_ready=0, busy=1 immediately. After release, a single normal sequence with no extra pulse.
